// File: rtl/mmc5_pkg.sv
// Shared MMC5 types: ExRAM mode encoding ($5104) and the ExRAM slot-grant encoding.
package mmc5_pkg;

    localparam int unsigned EXRAM_ADDR_W = 10;
    localparam int unsigned EXRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        EXR_NT     = 2'd0,
        EXR_EXATTR = 2'd1,
        EXR_RAM    = 2'd2,
        EXR_RAM_RO = 2'd3
    } exram_mode_t;

    typedef enum logic [1:0] {
        G_NONE  = 2'd0,
        G_PPU   = 2'd1,
        G_CPURD = 2'd2,
        G_WR    = 2'd3
    } grant_t;

endpackage

// File: rtl/mmc5_exram_bram.sv
// 1 KiB single-port synchronous ExRAM, read data registered (1-cycle latency, read-before-write).
module mmc5_exram_bram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/mmc5_exram_arbiter.sv
// Per-ce-slot arbiter for ExRAM between PPU fetches, CPU reads and a 2-entry posted write buffer
// with read-after-write forwarding and a starvation override for queued writes.
module mmc5_exram_arbiter
    import mmc5_pkg::*;
#(
    parameter int unsigned ADDR_W       = EXRAM_ADDR_W,
    parameter int unsigned DATA_W       = EXRAM_DATA_W,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_ce,
    input  logic [1:0]        i_exram_mode,
    input  logic              i_ppu_in_frame,
    input  logic              i_ppu_req,
    input  logic [ADDR_W-1:0] i_ppu_addr,
    output logic              o_ppu_valid,
    output logic [DATA_W-1:0] o_ppu_rdata,
    input  logic              i_cpu_rd_req,
    input  logic              i_cpu_wr_req,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_rd_valid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_wr_full,
    output logic              o_wr_overflow
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0] r_fifo_addr [2];
    logic [DATA_W-1:0] r_fifo_data [2];
    logic              r_rd_ptr, r_wr_ptr;
    logic [1:0]        r_count;
    logic [CNT_W-1:0]  r_starve;
    grant_t            r_grant, w_grant;
    logic              r_rd_pend;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_fwd_valid;
    logic [DATA_W-1:0] r_fwd_data;
    logic [DATA_W-1:0] r_ppu_rdata, r_cpu_rdata;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_ram_addr;

    exram_mode_t       w_mode;
    logic              w_ce, w_mode_ram, w_ppu_win, w_starve_max;
    logic              w_wr_en, w_push, w_pop, w_drop;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic              w_rd_new, w_rd_pend;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_wdata, w_ram_rdata;

    // Reset blocks the slot so nothing is granted or written in the reset cycle.
    assign w_ce         = i_ce & ~reset;
    assign w_mode       = exram_mode_t'(i_exram_mode);
    assign w_mode_ram   = (w_mode == EXR_RAM) || (w_mode == EXR_RAM_RO);
    assign w_ppu_win    = i_ppu_req & ~w_mode_ram;
    assign w_starve_max = (r_starve == CNT_W'(STARVE_LIMIT));

    // Pop is decided without looking at reads, so forwarding cannot loop back into the grant.
    assign w_pop     = w_ce & (r_count != 2'd0) & (w_starve_max | ~w_ppu_win);
    assign w_wr_en   = w_ce & i_cpu_wr_req & (w_mode != EXR_RAM_RO);
    assign w_wr_data = (!w_mode_ram && !i_ppu_in_frame) ? '0 : i_cpu_wdata;
    assign w_push    = w_wr_en & ((r_count != 2'd2) | w_pop);
    assign w_drop    = w_wr_en & (r_count == 2'd2) & ~w_pop;

    // Newest match wins: this cycle's write, then the younger entry, then the older one.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        if (r_count != 2'd0 && r_fifo_addr[r_rd_ptr] == i_cpu_addr) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_fifo_data[r_rd_ptr];
        end
        if (r_count == 2'd2 && r_fifo_addr[~r_rd_ptr] == i_cpu_addr) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_fifo_data[~r_rd_ptr];
        end
        if (w_push) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = w_wr_data;
        end
    end

    assign w_rd_new  = w_ce & i_cpu_rd_req;
    assign w_rd_pend = w_rd_new ? (w_mode_ram & ~w_fwd_hit) : r_rd_pend;
    assign w_rd_addr = w_rd_new ? i_cpu_addr : r_rd_addr;

    always_comb begin
        w_grant     = G_NONE;
        w_ram_addr  = r_ram_addr;
        w_ram_we    = 1'b0;
        w_ram_wdata = r_fifo_data[r_rd_ptr];
        if (w_pop) begin
            w_grant = G_WR;
        end else if (w_ce && w_ppu_win) begin
            w_grant = G_PPU;
        end else if (w_ce && w_rd_pend) begin
            w_grant = G_CPURD;
        end
        unique case (w_grant)
            G_WR: begin
                w_ram_addr = r_fifo_addr[r_rd_ptr];
                w_ram_we   = 1'b1;
            end
            G_PPU:   w_ram_addr = i_ppu_addr;
            G_CPURD: w_ram_addr = w_rd_addr;
            default: w_ram_addr = r_ram_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_starve    <= '0;
            r_grant     <= G_NONE;
            r_rd_pend   <= 1'b0;
            r_rd_addr   <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= '0;
            r_ppu_rdata <= '0;
            r_cpu_rdata <= '0;
            r_overflow  <= 1'b0;
            r_ram_addr  <= '0;
        end else if (i_ce) begin
            r_grant    <= w_grant;
            r_ram_addr <= w_ram_addr;
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= i_cpu_addr;
                r_fifo_data[r_wr_ptr] <= w_wr_data;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_starve <= '0;
            end else if (r_count != 2'd0 && w_grant == G_PPU && !w_starve_max) begin
                r_starve <= r_starve + 1'b1;
            end
            r_rd_pend   <= w_rd_pend & (w_grant != G_CPURD);
            r_rd_addr   <= w_rd_addr;
            r_fwd_valid <= w_rd_new & (~w_mode_ram | w_fwd_hit);
            if (w_rd_new) begin
                r_fwd_data <= w_mode_ram ? w_fwd_data : '1;
            end
            if (o_ppu_valid) begin
                r_ppu_rdata <= o_ppu_rdata;
            end
            if (o_cpu_rd_valid) begin
                r_cpu_rdata <= o_cpu_rdata;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Valid pulses come from held state, so a ce=0 gap simply defers them.
    assign o_ppu_valid    = w_ce & (r_grant == G_PPU);
    assign o_ppu_rdata    = o_ppu_valid ? w_ram_rdata : r_ppu_rdata;
    assign o_cpu_rd_valid = w_ce & (r_fwd_valid | (r_grant == G_CPURD));
    assign o_cpu_rdata    = !o_cpu_rd_valid ? r_cpu_rdata :
                            r_fwd_valid     ? r_fwd_data  : w_ram_rdata;
    assign o_wr_full      = (r_count == 2'd2);
    assign o_wr_overflow  = r_overflow;

    mmc5_exram_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bram (
        .clk   (clk),
        .addr  (w_ram_addr),
        .we    (w_ram_we),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_mmc5_exram_arbiter.sv
// Self-checking bench for mmc5_exram_arbiter: vector table plus hand-written corner sequences,
// with read data checked through per-port scoreboards.
module tb_mmc5_exram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic [1:0] mode;
    logic       in_frame;
    logic       ppu_req;
    logic [9:0] ppu_addr;
    logic       ppu_valid;
    logic [7:0] ppu_rdata;
    logic       cpu_rd_req;
    logic       cpu_wr_req;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_rd_valid;
    logic [7:0] cpu_rdata;
    logic       wr_full;
    logic       wr_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] cpu_q [$];
    logic [7:0] ppu_q [$];

    typedef struct {
        logic [1:0] mode;
        logic       frame;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    mmc5_exram_arbiter u_dut (
        .clk            (clk),
        .reset          (reset),
        .i_ce           (ce),
        .i_exram_mode   (mode),
        .i_ppu_in_frame (in_frame),
        .i_ppu_req      (ppu_req),
        .i_ppu_addr     (ppu_addr),
        .o_ppu_valid    (ppu_valid),
        .o_ppu_rdata    (ppu_rdata),
        .i_cpu_rd_req   (cpu_rd_req),
        .i_cpu_wr_req   (cpu_wr_req),
        .i_cpu_addr     (cpu_addr),
        .i_cpu_wdata    (cpu_wdata),
        .o_cpu_rd_valid (cpu_rd_valid),
        .o_cpu_rdata    (cpu_rdata),
        .o_wr_full      (wr_full),
        .o_wr_overflow  (wr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
        cpu_wr_req = 1'b1;
        cpu_addr   = a;
        cpu_wdata  = d;
        step();
        cpu_wr_req = 1'b0;
    endtask

    // Read that must return one cycle later (empty buffer, forward or open bus).
    task automatic cpu_read(input string name, input logic [9:0] a, input logic [7:0] e);
        cpu_rd_req = 1'b1;
        cpu_addr   = a;
        cpu_q.push_back(e);
        step();
        cpu_rd_req = 1'b0;
        @(negedge clk);
        check(name, cpu_rd_valid, 1);
        step();
    endtask

    task automatic ppu_read(input string name, input logic [9:0] a, input logic [7:0] e);
        ppu_req  = 1'b1;
        ppu_addr = a;
        ppu_q.push_back(e);
        step();
        ppu_req = 1'b0;
        @(negedge clk);
        check(name, ppu_valid, 1);
        step();
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_rd_valid) begin
                if (cpu_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cpu_rd_pulse: got unexpected pulse data %0h, required none", cpu_rdata);
                end else begin
                    check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
                end
            end
            if (ppu_valid) begin
                if (ppu_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ppu_pulse: got unexpected pulse data %0h, required none", ppu_rdata);
                end else begin
                    check("ppu_rdata", ppu_rdata, ppu_q.pop_front());
                end
            end
        end
    end

    initial begin
        vecs[0] = '{mode: 2'd2, frame: 1'b1, addr: 10'h005, wdata: 8'h3A, exp: 8'h3A};
        vecs[1] = '{mode: 2'd2, frame: 1'b0, addr: 10'h006, wdata: 8'hC5, exp: 8'hC5};
        vecs[2] = '{mode: 2'd1, frame: 1'b1, addr: 10'h100, wdata: 8'h5A, exp: 8'h5A};
        vecs[3] = '{mode: 2'd1, frame: 1'b0, addr: 10'h101, wdata: 8'h66, exp: 8'h00};
        vecs[4] = '{mode: 2'd0, frame: 1'b0, addr: 10'h010, wdata: 8'h77, exp: 8'h00};
        vecs[5] = '{mode: 2'd0, frame: 1'b1, addr: 10'h3FF, wdata: 8'h81, exp: 8'h81};
        vecs[6] = '{mode: 2'd3, frame: 1'b1, addr: 10'h006, wdata: 8'h99, exp: 8'hC5};
        vecs[7] = '{mode: 2'd2, frame: 1'b0, addr: 10'h2AA, wdata: 8'h3C, exp: 8'h3C};

        reset = 1'b1; ce = 1'b1; mode = 2'd0; in_frame = 1'b0;
        ppu_req = 1'b0; ppu_addr = '0; cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ppu_valid", ppu_valid, 0);
        check("rst_ppu_rdata", ppu_rdata, 0);
        check("rst_cpu_rd_valid", cpu_rd_valid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_wr_full", wr_full, 0);
        check("rst_wr_overflow", wr_overflow, 0);
        step();

        // Write under each mode/frame combination, read back via CPU (mode 2) and PPU (mode 0).
        foreach (vecs[i]) begin
            mode     = vecs[i].mode;
            in_frame = vecs[i].frame;
            cpu_write(vecs[i].addr, vecs[i].wdata);
            idle(3);
            mode = 2'd2;
            cpu_read("vec_cpu_latency", vecs[i].addr, vecs[i].exp);
            mode = 2'd0;
            ppu_read("vec_ppu_latency", vecs[i].addr, vecs[i].exp);
        end
        check("vec_no_overflow", wr_overflow, 0);

        // Forwarding: read the next cycle, and read+write in the same cycle.
        mode = 2'd2; in_frame = 1'b1;
        cpu_write(10'h005, 8'hB4);
        cpu_read("fwd_next_cycle", 10'h005, 8'hB4);
        cpu_wr_req = 1'b1; cpu_rd_req = 1'b1; cpu_addr = 10'h006; cpu_wdata = 8'h6D;
        cpu_q.push_back(8'h6D);
        step();
        cpu_wr_req = 1'b0; cpu_rd_req = 1'b0;
        @(negedge clk);
        check("fwd_same_cycle", cpu_rd_valid, 1);
        idle(3);
        cpu_read("drain_006", 10'h006, 8'h6D);
        cpu_read("drain_005", 10'h005, 8'hB4);
        mode = 2'd1;
        cpu_read("open_bus", 10'h005, 8'hFF);

        // Starvation: PPU every slot, one write queued; the write takes the 5th slot (k=4).
        mode = 2'd1; in_frame = 1'b1; ppu_addr = 10'h3FF;
        for (int k = 0; k < 7; k++) begin
            ppu_req = 1'b1;
            if (k == 0) begin
                cpu_wr_req = 1'b1; cpu_addr = 10'h200; cpu_wdata = 8'hE7;
            end
            if (k != 4) ppu_q.push_back(8'h81);
            step();
            cpu_wr_req = 1'b0;
            @(negedge clk);
            check($sformatf("starve_ppu_valid_k%0d", k), ppu_valid, (k != 4) ? 1 : 0);
        end
        ppu_req = 1'b0;
        step();
        check("starve_drained", wr_full, 0);
        mode = 2'd2;
        cpu_read("starve_ram_200", 10'h200, 8'hE7);

        // Overflow: fill the buffer while PPU-blocked, drop the third, then push+pop when full.
        reset = 1'b1;
        step();
        reset = 1'b0;
        mode = 2'd2;
        cpu_write(10'h022, 8'h5E);
        cpu_write(10'h023, 8'h5F);
        cpu_write(10'h030, 8'h34);
        idle(4);
        mode = 2'd1; in_frame = 1'b1; ppu_req = 1'b1; ppu_addr = 10'h3FF;
        cpu_wr_req = 1'b1; cpu_addr = 10'h020; cpu_wdata = 8'hA1; ppu_q.push_back(8'h81);
        step();
        check("ovf_not_full_1", wr_full, 0);
        cpu_addr = 10'h021; cpu_wdata = 8'hA2; ppu_q.push_back(8'h81);
        step();
        check("ovf_full_2", wr_full, 1);
        check("ovf_clear_2", wr_overflow, 0);
        cpu_addr = 10'h022; cpu_wdata = 8'hA3; ppu_q.push_back(8'h81);
        step();
        check("ovf_set", wr_overflow, 1);
        ppu_req = 1'b0; mode = 2'd2; cpu_addr = 10'h023; cpu_wdata = 8'hA4;
        step();
        cpu_wr_req = 1'b0;
        check("ovf_push_pop_full", wr_full, 1);
        idle(3);
        check("ovf_drained", wr_full, 0);
        check("ovf_sticky", wr_overflow, 1);
        cpu_read("ovf_ram_020", 10'h020, 8'hA1);
        cpu_read("ovf_ram_021", 10'h021, 8'hA2);
        cpu_read("ovf_ram_022", 10'h022, 8'h5E);
        cpu_read("ovf_ram_023", 10'h023, 8'hA4);

        // Reset in the same cycle as a PPU grant, with a write still buffered.
        mode = 2'd1; in_frame = 1'b1;
        cpu_write(10'h030, 8'h12);
        ppu_req = 1'b1; ppu_addr = 10'h3FF; reset = 1'b1;
        step();
        reset = 1'b0; ppu_req = 1'b0;
        @(negedge clk);
        check("rst2_ppu_valid", ppu_valid, 0);
        check("rst2_ppu_rdata", ppu_rdata, 0);
        check("rst2_cpu_rd_valid", cpu_rd_valid, 0);
        check("rst2_cpu_rdata", cpu_rdata, 0);
        check("rst2_wr_full", wr_full, 0);
        check("rst2_wr_overflow", wr_overflow, 0);
        step();
        mode = 2'd2;
        cpu_read("rst2_write_discarded", 10'h030, 8'h34);

        // ce gaps during a CPU read: pulse deferred to the next ce=1 cycle, exactly once.
        mode = 2'd2;
        cpu_rd_req = 1'b1; cpu_addr = 10'h100; cpu_q.push_back(8'h5A);
        step();
        cpu_rd_req = 1'b0; ce = 1'b0;
        @(negedge clk);
        check("ce_gap_1", cpu_rd_valid, 0);
        step();
        @(negedge clk);
        check("ce_gap_2", cpu_rd_valid, 0);
        step();
        ce = 1'b1;
        @(negedge clk);
        check("ce_pulse", cpu_rd_valid, 1);
        step();
        @(negedge clk);
        check("ce_single_pulse", cpu_rd_valid, 0);
        check("ce_rdata_held", cpu_rdata, 8'h5A);
        step();

        idle(2);
        check("cpu_q_drained", cpu_q.size(), 0);
        check("ppu_q_drained", ppu_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
